// File: rtl/gate_probe_pkg.sv
// Shared definitions for the gate prober: gate classification codes,
// reference truth patterns and the probe FSM state type.
package gate_probe_pkg;

  typedef enum logic [2:0] {
    GATE_UNKNOWN = 3'd0,
    GATE_AND     = 3'd1,
    GATE_OR      = 3'd2,
    GATE_NAND    = 3'd3,
    GATE_NOR     = 3'd4,
    GATE_XOR     = 3'd5,
    GATE_XNOR    = 3'd6,
    GATE_NOT_A   = 3'd7
  } gate_code_e;

  // Bit k of each pattern is the gate output for input vector {a,b} = k.
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_XNOR  = 4'b1001;
  localparam logic [3:0] TT_NOT_A = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gate_classify.sv
// Combinational mapping from a measured 4-bit truth table to a gate code.
module gate_classify
  import gate_probe_pkg::*;
(
  input  logic [3:0] truth_i,
  output gate_code_e gate_id_o
);

  always_comb begin
    gate_id_o = GATE_UNKNOWN;
    case (truth_i)
      TT_AND:   gate_id_o = GATE_AND;
      TT_OR:    gate_id_o = GATE_OR;
      TT_NAND:  gate_id_o = GATE_NAND;
      TT_NOR:   gate_id_o = GATE_NOR;
      TT_XOR:   gate_id_o = GATE_XOR;
      TT_XNOR:  gate_id_o = GATE_XNOR;
      TT_NOT_A: gate_id_o = GATE_NOT_A;
      default:  gate_id_o = GATE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_prober.sv
// Steps a 2-input gate through all four input vectors, samples its output
// after a settle window, and reports the truth table plus a gate code.
module gate_prober
  import gate_probe_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_c,
  output logic [3:0] truth,
  output logic [2:0] gate_id
);

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] shadow_q, shadow_d;
  logic [3:0] truth_q, truth_d;
  gate_code_e gate_id_q, gate_id_d;

  logic [3:0] shadow_smp;
  gate_code_e cls_id;

  // Shadow table with the current vector's sample merged in; this is what
  // gets committed on the final sample so truth and gate_id move together.
  always_comb begin
    shadow_smp         = shadow_q;
    shadow_smp[vec_q]  = dut_c;
  end

  gate_classify u_classify (
    .truth_i   (shadow_smp),
    .gate_id_o (cls_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= 2'd0;
      hold_q    <= 4'd0;
      shadow_q  <= 4'd0;
      truth_q   <= 4'd0;
      gate_id_q <= GATE_UNKNOWN;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      hold_q    <= hold_d;
      shadow_q  <= shadow_d;
      truth_q   <= truth_d;
      gate_id_q <= gate_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    hold_d    = hold_q;
    shadow_d  = shadow_q;
    truth_d   = truth_q;
    gate_id_d = gate_id_q;
    busy      = 1'b0;
    done      = 1'b0;
    dut_a     = 1'b0;
    dut_b     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_RUN;
          vec_d    = 2'd0;
          hold_d   = 4'd0;
          shadow_d = 4'd0;
        end
      end
      ST_RUN: begin
        busy  = 1'b1;
        dut_a = vec_q[1];
        dut_b = vec_q[0];
        if (hold_q == HOLD_LAST) begin
          hold_d   = 4'd0;
          shadow_d = shadow_smp;
          // Vector 3 is the last one: commit instead of advancing the index.
          if (vec_q == 2'd3) begin
            state_d   = ST_DONE;
            vec_d     = 2'd0;
            truth_d   = shadow_smp;
            gate_id_d = cls_id;
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign truth   = truth_q;
  assign gate_id = gate_id_q;

endmodule

// File: tb/tb_gate_prober.sv
// Directed bench for gate_prober: two instances (SETTLE_CYCLES 1 and 2)
// each probing a behavioural gate model, with a scoreboard of expected results.
module tb_gate_prober;

  typedef struct packed {
    logic [3:0] t;
    logic [2:0] g;
  } exp_s;

  logic clk;
  logic rst_n;
  logic start1, start2;
  logic busy1, busy2, done1, done2;
  logic a1, b1, c1, a2, b2, c2;
  logic [3:0] truth1, truth2;
  logic [2:0] gid1, gid2;
  logic nreg1, nreg2;
  int mode1, mode2;

  int checks;
  int errors;
  exp_s sb_q[$];
  logic [3:0] last_t [2];
  logic [2:0] last_g [2];

  bit sel_g;
  logic busy_s, done_s, a_s, b_s;
  logic [3:0] truth_s;
  logic [2:0] gid_s;

  gate_prober #(.SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .truth(truth1), .gate_id(gid1)
  );

  gate_prober #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .dut_a(a2), .dut_b(b2), .dut_c(c2), .truth(truth2), .gate_id(gid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode: 0 const 0, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 NOR with registered output
  function automatic logic gate_model(input int mode, input logic a, input logic b,
                                      input logic r);
    case (mode)
      1:       return a & b;
      2:       return a | b;
      3:       return ~(a & b);
      4:       return ~(a | b);
      5:       return a ^ b;
      6:       return r;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    nreg1 <= ~(a1 | b1);
    nreg2 <= ~(a2 | b2);
  end

  assign c1 = gate_model(mode1, a1, b1, nreg1);
  assign c2 = gate_model(mode2, a2, b2, nreg2);

  assign busy_s  = sel_g ? busy2  : busy1;
  assign done_s  = sel_g ? done2  : done1;
  assign a_s     = sel_g ? a2     : a1;
  assign b_s     = sel_g ? b2     : b1;
  assign truth_s = sel_g ? truth2 : truth1;
  assign gid_s   = sel_g ? gid2   : gid1;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start2 = v;
    else     start1 = v;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy_s,  8'd0);
    check({tag, "_done"},  done_s,  8'd0);
    check({tag, "_a"},     a_s,     8'd0);
    check({tag, "_b"},     b_s,     8'd0);
    check({tag, "_truth"}, truth_s, 8'd0);
    check({tag, "_gid"},   gid_s,   8'd0);
  endtask

  // Called on a negedge in an IDLE cycle; returns on the negedge of the IDLE
  // cycle following DONE.
  task automatic run_probe(input bit sel, input int mode, input logic [3:0] et,
                           input logic [2:0] eg, input bit hold_start);
    int s;
    int n;
    exp_s e;
    logic [1:0] kv;
    sel_g = sel;
    s = sel ? 2 : 1;
    n = 4 * (s + 1);
    if (sel) mode2 = mode;
    else     mode1 = mode;
    #1;
    check("idle_busy", busy_s, 8'd0);
    set_start(sel, 1'b1);
    e.t = et;
    e.g = eg;
    sb_q.push_back(e);
    @(negedge clk);
    if (!hold_start) set_start(sel, 1'b0);
    for (int i = 0; i < n; i++) begin
      kv = 2'(i / (s + 1));
      check("run_busy",  busy_s,  8'd1);
      check("run_done",  done_s,  8'd0);
      check("run_a",     a_s,     {7'd0, kv[1]});
      check("run_b",     b_s,     {7'd0, kv[0]});
      check("run_truth", truth_s, {4'd0, last_t[sel]});
      check("run_gid",   gid_s,   {5'd0, last_g[sel]});
      @(negedge clk);
    end
    check("end_busy", busy_s, 8'd0);
    check("end_done", done_s, 8'd1);
    check("end_a",    a_s,    8'd0);
    check("end_b",    b_s,    8'd0);
    check("sb_nonempty", 8'(sb_q.size() > 0), 8'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("end_truth", truth_s, {4'd0, e.t});
      check("end_gid",   gid_s,   {5'd0, e.g});
      last_t[sel] = e.t;
      last_g[sel] = e.g;
    end
    @(negedge clk);
    check("idle_done",  done_s,  8'd0);
    check("idle_busy2", busy_s,  8'd0);
    check("hold_truth", truth_s, {4'd0, last_t[sel]});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode1  = 0;
    mode2  = 0;
    sel_g  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_t[i] = 4'd0;
      last_g[i] = 3'd0;
    end

    repeat (2) @(negedge clk);
    sel_g = 1'b0;
    #1 check_reset_outputs("rst_s1");
    sel_g = 1'b1;
    #1 check_reset_outputs("rst_s2");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_probe(1'b1, 1, 4'b1000, 3'd1, 1'b0);   // AND, settle 2
    run_probe(1'b0, 5, 4'b0110, 3'd5, 1'b0);   // XOR, settle 1
    run_probe(1'b0, 0, 4'b0000, 3'd0, 1'b0);   // output stuck at 0
    run_probe(1'b0, 6, 4'b0001, 3'd4, 1'b0);   // registered NOR
    run_probe(1'b1, 2, 4'b1110, 3'd2, 1'b1);   // OR, start held high
    run_probe(1'b1, 2, 4'b1110, 3'd2, 1'b0);

    // Abort a NAND run at its 5th busy cycle.
    sel_g = 1'b1;
    mode2 = 3;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    #1 check("pre_abort_busy", busy2, 8'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    last_t[0] = 4'd0; last_g[0] = 3'd0;
    last_t[1] = 4'd0; last_g[1] = 3'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("post_abort_done", done2, 8'd0);
      check("post_abort_busy", busy2, 8'd0);
    end
    check("post_abort_truth", truth2, 8'd0);
    run_probe(1'b1, 3, 4'b0111, 3'd3, 1'b0);   // NAND after abort

    check("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_prober.md
GATE_PROBER -- requirements
Module: gate_prober

Interface
REQ-001 SETTLE_CYCLES, default 2, number of extra cycles each input vector is held before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to probe the attached 2-input gate; accepted only in IDLE.
REQ-005 busy  output  1  high while a probe run is in progress.
REQ-006 done  output  1  one-cycle pulse marking the end of a run; truth and gate_id are valid from this cycle.
REQ-007 dut_a  output  1  drives input a of the gate under probe.
REQ-008 dut_b  output  1  drives input b of the gate under probe.
REQ-009 dut_c  input  1  output c of the gate under probe.
REQ-010 truth  output  4  measured truth table; truth[k] is c for vector k, where {a,b}=k.
REQ-011 gate_id  output  3  classification code of truth, from the shared gate-code set.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 Transitions SHALL be:
- IDLE->RUN on start=1 at an edge;
- RUN->DONE after the edge that samples vector 3;
- DONE->IDLE unconditionally after one cycle.
REQ-014 In RUN, vectors k=0,1,2,3 SHALL be driven in order as dut_a=k[1], dut_b=k[0]; each vector is held SETTLE_CYCLES+1 cycles.
REQ-015 dut_c SHALL be sampled into truth[k] at the edge ending the last hold cycle of vector k.
REQ-016 busy SHALL be 1 for exactly 4*(SETTLE_CYCLES+1) cycles, starting the cycle after the start edge.
REQ-017 done SHALL be 1 for exactly one cycle, the DONE cycle; busy SHALL be 0 in that cycle.
REQ-018 dut_a and dut_b SHALL be 0 whenever busy=0.
REQ-019 truth and gate_id SHALL update together at the RUN->DONE edge, and hold until the next RUN->DONE edge.
REQ-020 Intermediate truth bits SHALL be built in an internal shadow register and SHALL NOT be visible on truth mid-run.
REQ-021 gate_id SHALL map truth as:
- 1000 AND, 1110 OR, 0111 NAND, 0001 NOR;
- 0110 XOR, 1001 XNOR, 0011 NOT_A;
- every other value UNKNOWN.
REQ-022 start while busy=1 or in DONE SHALL be ignored; a held start SHALL begin a new run from the IDLE cycle that follows DONE.
REQ-023 The hold counter SHALL wrap to 0 at each vector change; the vector index SHALL NOT wrap within a run.

Reset
REQ-024 On rst_n=0, asynchronously and regardless of state:
- state=IDLE;
- busy=0, done=0, dut_a=0, dut_b=0;
- truth=0000, gate_id=UNKNOWN;
- counters and shadow register cleared.
REQ-025 Reset during RUN SHALL abort the run with no done pulse; the first start after rst_n rises SHALL begin a full run from vector 0.

Structure
REQ-026 Package gate_probe_pkg SHALL hold the 3-bit gate-code enumeration (UNKNOWN=0, AND, OR, NAND, NOR, XOR, XNOR, NOT_A), the truth-pattern constants and the FSM state type.
REQ-027 Classification SHALL be a combinational sub-module gate_classify (truth in, gate_id out); gate_prober SHALL register its result.

Verification
REQ-028 AND model, SETTLE_CYCLES=2, one start pulse -> busy high 12 cycles; then done for 1 cycle with truth=1000 and gate_id=AND; dut_a/dut_b sequence 00,01,10,11, 3 cycles each.
REQ-029 XOR model, SETTLE_CYCLES=1 -> busy 8 cycles, truth=0110, gate_id=XOR.
REQ-030 dut_c tied 0 -> truth=0000, gate_id=UNKNOWN, done still pulses once.
REQ-031 NOR model with a 1-cycle registered output, SETTLE_CYCLES=1 -> truth=0001, gate_id=NOR.
REQ-032 start held high with OR model -> back-to-back runs separated by DONE+IDLE cycles; each run reports 1110/OR; no start accepted while busy.
REQ-033 rst_n low for 1 cycle at the 5th busy cycle of a NAND run -> all outputs at reset values and no done; the next start yields 0111/NAND.
